// File: rtl/load_store_unit_if.sv
// Word-organised data-memory bus between the load/store unit and memory.
interface load_store_unit_if #(parameter int unsigned n = 32);
    localparam int unsigned LANES = 4;

    logic             mem_req;
    logic             mem_we;
    logic [n-1:0]     mem_addr;
    logic [LANES-1:0] mem_be;
    logic [n-1:0]     mem_wdata;
    logic [n-1:0]     mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load or store per request, with alignment,
// byte-enable, lane replication and load extension; faults bypass memory.
module load_store_unit #(
    parameter int unsigned n = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [n-1:0]        addr_in,
    input  logic [n-1:0]        store_data,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [n-1:0]        load_data,
    load_store_unit_if.master   bus
);
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, FIN, ERR} state_t;

    state_t     state;
    logic [2:0] f3_q;
    logic [1:0] lane_q;
    logic       load_q;

    logic             legal_c;
    logic             aligned_c;
    logic [LANES-1:0] be_c;
    logic [n-1:0]     wdata_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [n-1:0]     ext_c;

    // Request decode on the live inputs, consumed only when start is taken in IDLE.
    always_comb begin
        legal_c   = 1'b0;
        aligned_c = 1'b0;
        be_c      = LANES'(4'b1111);
        wdata_c   = store_data;
        if (is_load && !is_store)
            legal_c = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store && !is_load)
            legal_c = funct3 inside {3'b000, 3'b001, 3'b010};
        case (funct3[1:0])
            2'b00: begin
                aligned_c = 1'b1;
                be_c      = LANES'(4'b0001 << addr_in[1:0]);
                wdata_c   = n'({4{store_data[7:0]}});
            end
            2'b01: begin
                aligned_c = ~addr_in[0];
                be_c      = LANES'(4'b0011 << addr_in[1:0]);
                wdata_c   = n'({2{store_data[15:0]}});
            end
            2'b10:   aligned_c = (addr_in[1:0] == 2'b00);
            default: aligned_c = 1'b0;
        endcase
    end

    // Lane extraction from the returned word using the latched request.
    always_comb begin
        byte_c = bus.mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_c = bus.mem_rdata[7:0];
            2'd1:    byte_c = bus.mem_rdata[15:8];
            2'd2:    byte_c = bus.mem_rdata[23:16];
            default: byte_c = bus.mem_rdata[31:24];
        endcase
        half_c = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ext_c = f3_q[2] ? n'({24'd0, byte_c}) : n'({{24{byte_c[7]}}, byte_c});
            2'b01:   ext_c = f3_q[2] ? n'({16'd0, half_c}) : n'({{16{half_c[15]}}, half_c});
            default: ext_c = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            f3_q          <= 3'd0;
            lane_q        <= 2'd0;
            load_q        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            load_data     <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        f3_q   <= funct3;
                        lane_q <= addr_in[1:0];
                        load_q <= is_load;
                        busy   <= 1'b1;
                        if (legal_c && aligned_c) begin
                            state         <= ACCESS;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= is_store;
                            bus.mem_addr  <= {addr_in[n-1:2], 2'b00};
                            bus.mem_be    <= be_c;
                            bus.mem_wdata <= wdata_c;
                        end else begin
                            state <= ERR;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        state       <= FIN;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        done        <= 1'b1;
                        if (load_q) load_data <= ext_c;
                    end
                end
                FIN, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
